// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared instruction widths, opcodes and issue FSM encoding
//
// Purpose: common definitions for the pixel_generator front end.
// Ports:   none (package).
package gpu_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 8;

  localparam logic [OPCODE_W-1:0] OP_NOP                = 8'h00;
  localparam logic [OPCODE_W-1:0] OP_SET_BG_COLOR       = 8'h01;
  localparam logic [OPCODE_W-1:0] OP_SET_RED_BG_COLOR   = 8'h02;
  localparam logic [OPCODE_W-1:0] OP_SET_GREEN_BG_COLOR = 8'h03;
  localparam logic [OPCODE_W-1:0] OP_SET_BLUE_BG_COLOR  = 8'h04;
  localparam logic [OPCODE_W-1:0] OP_SET_BLACK_BG_COLOR = 8'h05;
  localparam logic [OPCODE_W-1:0] OP_SET_WHITE_BG_COLOR = 8'h06;
  localparam logic [OPCODE_W-1:0] OP_SET_PIXEL          = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } issue_state_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_W-1:0];
  endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// rtl/gpu_sync_fifo.sv - in-order synchronous FIFO with head-of-queue data
//
// Purpose: small queue between the requester arbiter and the issue FSM.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset (flushes queue)
//   push, push_data    write one entry (ignored when full)
//   pop                remove the head entry (ignored when empty)
//   full, empty, count occupancy status
//   head               data of the oldest entry
module gpu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_instruction_arbiter.sv
// rtl/gpu_instruction_arbiter.sv - round-robin instruction arbiter and paced issuer for pixel_generator
//
// Purpose: merges two instruction requesters into an in-order queue and issues
// entries as spaced single-cycle strobes, holding SET_PIXEL until vblank.
// Ports:
//   i_clk, i_reset_n                         clock, synchronous active-low reset
//   i_req0_instruction/valid, o_req0_ready   requester 0 handshake
//   i_req1_instruction/valid, o_req1_ready   requester 1 handshake
//   i_vblank                                 vertical blanking level
//   o_instruction, o_instruction_ready       issue strobe and its payload
//   o_fifo_count                             queue occupancy
//   o_busy                                   work queued or in flight
module gpu_instruction_arbiter
  import gpu_pkg::*;
#(
  parameter int                  DEPTH        = 4,
  parameter int                  SPACING      = 2,
  parameter logic [OPCODE_W-1:0] PIXEL_OPCODE = 8'h07
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [INSTR_W-1:0]     i_req0_instruction,
  input  logic                   i_req0_valid,
  output logic                   o_req0_ready,
  input  logic [INSTR_W-1:0]     i_req1_instruction,
  input  logic                   i_req1_valid,
  output logic                   o_req1_ready,
  input  logic                   i_vblank,
  output logic [INSTR_W-1:0]     o_instruction,
  output logic                   o_instruction_ready,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_busy
);

  localparam int GW = (SPACING > 1) ? $clog2(SPACING + 1) : 1;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [INSTR_W-1:0]     fifo_head;
  logic                   fifo_push;
  logic                   fifo_pop;

  logic                   rr_ptr;      // 0: req0 has priority, 1: req1
  logic                   req0_wins;
  logic                   req1_wins;
  logic                   accept0;
  logic                   accept1;
  logic [INSTR_W-1:0]     accept_instr;

  issue_state_t           state;
  logic [GW-1:0]          gap_cnt;
  logic                   head_gated;
  logic                   stage_valid;
  logic [INSTR_W-1:0]     stage_data;

  gpu_sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (fifo_push),
    .push_data (accept_instr),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // A requester is ready unless the queue is full or the other side wins.
  // Idle requesters therefore see ready high, which is harmless.
  assign req0_wins    = i_req0_valid && (!i_req1_valid || !rr_ptr);
  assign req1_wins    = i_req1_valid && (!i_req0_valid ||  rr_ptr);
  assign o_req0_ready = !fifo_full && !req1_wins;
  assign o_req1_ready = !fifo_full && !req0_wins;
  assign accept0      = i_req0_valid && o_req0_ready;
  assign accept1      = i_req1_valid && o_req1_ready;
  assign accept_instr = accept1 ? i_req1_instruction : i_req0_instruction;

  // NOPs complete the handshake but never occupy a queue slot.
  assign fifo_push = (accept0 || accept1) && (opcode_of(accept_instr) != OP_NOP);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rr_ptr <= 1'b0;
    end else if (accept0) begin
      rr_ptr <= 1'b1;
    end else if (accept1) begin
      rr_ptr <= 1'b0;
    end
  end

  // Pixel writes at the head block everything behind them until vblank.
  assign head_gated = (opcode_of(fifo_head) == PIXEL_OPCODE) && !i_vblank;
  assign fifo_pop   = ((state == ST_IDLE) || (state == ST_HOLD)) && !fifo_empty && !head_gated;

  // The popped head sits one cycle in stage_* before it is strobed out, giving
  // two cycles from acceptance to strobe. Once popped it always issues.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state               <= ST_IDLE;
      gap_cnt             <= '0;
      stage_valid         <= 1'b0;
      stage_data          <= '0;
      o_instruction       <= '0;
      o_instruction_ready <= 1'b0;
    end else begin
      o_instruction_ready <= stage_valid;
      o_instruction       <= stage_valid ? stage_data : '0;
      stage_valid         <= 1'b0;
      stage_data          <= '0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (fifo_pop) begin
            stage_valid <= 1'b1;
            stage_data  <= fifo_head;
            gap_cnt     <= '0;
            state       <= (SPACING > 1) ? ST_GAP : ST_IDLE;
          end else if (!fifo_empty) begin
            state <= ST_HOLD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          // GAP lasts SPACING-1 cycles counting the pop cycle's successor.
          if (int'(gap_cnt) >= SPACING - 2) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_fifo_count = fifo_count;
  assign o_busy       = !fifo_empty || (state != ST_IDLE) || stage_valid;

endmodule

// File: tb/tb_gpu_instruction_arbiter.sv
// tb/tb_gpu_instruction_arbiter.sv - directed self-checking bench for gpu_instruction_arbiter
module tb_gpu_instruction_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] i_req0_instruction = '0;
  logic        i_req0_valid = 1'b0;
  logic        o_req0_ready;
  logic [31:0] i_req1_instruction = '0;
  logic        i_req1_valid = 1'b0;
  logic        o_req1_ready;
  logic        i_vblank = 1'b0;
  logic [31:0] o_instruction;
  logic        o_instruction_ready;
  logic [2:0]  o_fifo_count;
  logic        o_busy;

  gpu_instruction_arbiter #(
    .DEPTH        (4),
    .SPACING      (2),
    .PIXEL_OPCODE (8'h07)
  ) dut (
    .i_clk               (i_clk),
    .i_reset_n           (i_reset_n),
    .i_req0_instruction  (i_req0_instruction),
    .i_req0_valid        (i_req0_valid),
    .o_req0_ready        (o_req0_ready),
    .i_req1_instruction  (i_req1_instruction),
    .i_req1_valid        (i_req1_valid),
    .o_req1_ready        (o_req1_ready),
    .i_vblank            (i_vblank),
    .o_instruction       (o_instruction),
    .o_instruction_ready (o_instruction_ready),
    .o_fifo_count        (o_fifo_count),
    .o_busy              (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int          nvec = 0;
  int          nerr = 0;
  int          viol = 0;
  int          s_cyc[$];
  logic [31:0] s_dat[$];
  int          g_cyc[$];
  int          g_who[$];
  logic        prev_rdy = 1'b0;

  // Strobe and grant log, sampled mid-cycle. Grants are stamped with the
  // edge that completes them; strobes with the edge that raised them.
  always @(negedge i_clk) begin
    if (o_instruction_ready) begin
      s_cyc.push_back(cyc);
      s_dat.push_back(o_instruction);
    end
    if (!o_instruction_ready && o_instruction != 32'h0) viol++;
    if (o_instruction_ready && prev_rdy) viol++;
    prev_rdy = o_instruction_ready;
    if (i_req0_valid && o_req0_ready) begin
      g_cyc.push_back(cyc + 1);
      g_who.push_back(0);
    end
    if (i_req1_valid && o_req1_ready) begin
      g_cyc.push_back(cyc + 1);
      g_who.push_back(1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic clear_logs();
    s_cyc.delete();
    s_dat.delete();
    g_cyc.delete();
    g_who.delete();
  endtask

  task automatic do_reset();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    i_vblank     = 1'b0;
    i_reset_n    = 1'b0;
    tick(1);
    i_reset_n = 1'b1;
    clear_logs();
  endtask

  function automatic int at_i(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] at_d(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int e;
    int v;
    int idx0;
    int idx1;
    logic g0;
    logic g1;
    logic [31:0] l0 [3];
    logic [31:0] l1 [3];
    logic [31:0] exp_order [6];
    logic [31:0] pix [5];

    // Reset then idle.
    tick(2);
    i_reset_n = 1'b1;
    tick(1);
    check("rst_strobe", o_instruction_ready, 0);
    check("rst_instr", o_instruction, 0);
    check("rst_count", o_fifo_count, 0);
    check("rst_ready0", o_req0_ready, 1);
    check("rst_ready1", o_req1_ready, 1);
    check("rst_busy", o_busy, 0);

    // Single instruction: strobe two edges after acceptance.
    clear_logs();
    i_req0_valid = 1'b1;
    i_req0_instruction = 32'h0000_0002;
    #1;
    check("single_ready0", o_req0_ready, 1);
    tick(1);
    e = cyc;
    i_req0_valid = 1'b0;
    tick(5);
    check("single_nstrobe", s_cyc.size(), 1);
    check("single_cyc", at_i(s_cyc, 0), e + 2);
    check("single_data", at_d(s_dat, 0), 32'h0000_0002);

    // Both requesters valid: alternating grants, strobes every 2nd cycle.
    do_reset();
    l0 = '{32'h0000_0A02, 32'h0000_0A04, 32'h0000_0A06};
    l1 = '{32'h0000_0B03, 32'h0000_0B05, 32'h0000_0B01};
    exp_order = '{32'h0000_0A02, 32'h0000_0B03, 32'h0000_0A04,
                  32'h0000_0B05, 32'h0000_0A06, 32'h0000_0B01};
    idx0 = 0;
    idx1 = 0;
    for (int k = 0; k < 6; k++) begin
      i_req0_valid = (idx0 < 3);
      i_req1_valid = (idx1 < 3);
      i_req0_instruction = l0[(idx0 < 3) ? idx0 : 2];
      i_req1_instruction = l1[(idx1 < 3) ? idx1 : 2];
      #1;
      g0 = i_req0_valid && o_req0_ready;
      g1 = i_req1_valid && o_req1_ready;
      tick(1);
      if (g0) idx0++;
      if (g1) idx1++;
    end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    tick(14);
    check("rr_ngrant", g_who.size(), 6);
    check("rr_nstrobe", s_cyc.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_who%0d", k), at_i(g_who, k), k % 2);
      check($sformatf("rr_data%0d", k), at_d(s_dat, k), exp_order[k]);
      check($sformatf("rr_cyc%0d", k), at_i(s_cyc, k), at_i(g_cyc, 0) + 2 + 2 * k);
    end

    // SET_PIXEL held until vblank, blocking the instruction behind it.
    do_reset();
    i_req0_valid = 1'b1;
    i_req0_instruction = 32'h0012_3407;
    tick(1);
    i_req0_instruction = 32'h0000_0003;
    tick(1);
    i_req0_valid = 1'b0;
    tick(6);
    check("vb_nostrobe", s_cyc.size(), 0);
    check("vb_busy", o_busy, 1);
    check("vb_count", o_fifo_count, 2);
    v = cyc;
    i_vblank = 1'b1;
    tick(8);
    check("vb_nstrobe", s_cyc.size(), 2);
    check("vb_cyc0", at_i(s_cyc, 0), v + 2);
    check("vb_data0", at_d(s_dat, 0), 32'h0012_3407);
    check("vb_cyc1", at_i(s_cyc, 1), v + 4);
    check("vb_data1", at_d(s_dat, 1), 32'h0000_0003);
    i_vblank = 1'b0;

    // Fill with gated pixels, stall a fifth, then drain on vblank.
    do_reset();
    for (int k = 0; k < 5; k++) pix[k] = {16'h0, 8'(k + 1), 8'h07};
    i_req0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_req0_instruction = pix[k];
      tick(1);
    end
    i_req0_instruction = pix[4];
    #1;
    check("full_count", o_fifo_count, 4);
    check("full_ready0", o_req0_ready, 0);
    check("full_ready1", o_req1_ready, 0);
    tick(3);
    check("full_stall_count", o_fifo_count, 4);
    check("full_stall_grants", g_cyc.size(), 4);
    v = cyc;
    i_vblank = 1'b1;
    tick(1);
    check("drain_count3", o_fifo_count, 3);
    tick(1);
    i_req0_valid = 1'b0;
    check("fifth_grant_cyc", at_i(g_cyc, 4), v + 2);
    tick(12);
    check("drain_count0", o_fifo_count, 0);
    check("drain_nstrobe", s_cyc.size(), 5);
    check("drain_data4", at_d(s_dat, 4), pix[4]);
    check("drain_busy", o_busy, 0);
    i_vblank = 1'b0;

    // NOP: handshake completes, nothing queued or issued.
    do_reset();
    i_req0_valid = 1'b1;
    i_req0_instruction = 32'h0000_0000;
    #1;
    check("nop_ready", o_req0_ready, 1);
    tick(1);
    i_req0_valid = 1'b0;
    check("nop_count", o_fifo_count, 0);
    tick(5);
    check("nop_nstrobe", s_cyc.size(), 0);
    check("nop_busy", o_busy, 0);

    // Reset mid-operation flushes queue and restores req0 priority.
    do_reset();
    i_req0_valid = 1'b1;
    i_req0_instruction = 32'h0000_5507;
    tick(3);
    i_req0_valid = 1'b0;
    check("mid_count3", o_fifo_count, 3);
    i_reset_n = 1'b0;
    tick(1);
    check("mid_rst_count", o_fifo_count, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_strobe", o_instruction_ready, 0);
    i_reset_n = 1'b1;
    clear_logs();
    i_vblank = 1'b1;
    tick(6);
    check("mid_nostrobe", s_cyc.size(), 0);
    i_req0_valid = 1'b1;
    i_req0_instruction = 32'h0000_0002;
    i_req1_valid = 1'b1;
    i_req1_instruction = 32'h0000_0003;
    #1;
    check("mid_ptr_ready0", o_req0_ready, 1);
    check("mid_ptr_ready1", o_req1_ready, 0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    i_vblank = 1'b0;
    tick(2);

    check("strobe_shape_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
